// File: rtl/ycbcr444_to_422.sv
// 4:4:4 to 4:2:2 chroma pairing with optional averaging.
// Even pixel is held; its pair emits {Y0,Cb} then {Y1,Cr}.
module ycbcr444_to_422 #(
  parameter bit P_AVG = 1'b1
) (
  input  logic        i_pclk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_Y,
  input  logic [7:0]  i_Cb,
  input  logic [7:0]  i_Cr,
  input  logic [2:0]  i_tags,
  input  logic        i_clr_err,
  output logic        o_valid,
  output logic [15:0] o_data,
  output logic [2:0]  o_tags,
  output logic        o_err
);

  logic        pend;
  logic [7:0]  y0, cb0, cr0;
  logic [2:0]  t0;

  logic        sec_v;
  logic [15:0] sec_data;
  logic [2:0]  sec_tags;

  logic        vld_q;
  logic [15:0] data_q;
  logic [2:0]  tags_q;
  logic        err_q;

  logic        start, is_even;
  logic        take_even, take_odd;
  logic        lone, orphan;
  logic [8:0]  sum_cb, sum_cr;
  logic [7:0]  cb_out, cr_out;

  always_comb begin
    start     = i_tags[0] | i_tags[1];
    is_even   = ~pend | start;
    take_even = i_valid & is_even;
    take_odd  = i_valid & ~is_even;
    lone      = take_even & i_tags[2];
    orphan    = i_valid & pend & start;
    sum_cb    = {1'b0, cb0} + {1'b0, i_Cb} + 9'd1;
    sum_cr    = {1'b0, cr0} + {1'b0, i_Cr} + 9'd1;
    cb_out    = P_AVG ? sum_cb[8:1] : cb0;
    cr_out    = P_AVG ? sum_cr[8:1] : cr0;
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      pend     <= 1'b0;
      y0       <= '0;
      cb0      <= '0;
      cr0      <= '0;
      t0       <= '0;
      sec_v    <= 1'b0;
      sec_data <= '0;
      sec_tags <= '0;
      vld_q    <= 1'b0;
      data_q   <= '0;
      tags_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (take_even) begin
        y0   <= i_Y;
        cb0  <= i_Cb;
        cr0  <= i_Cr;
        t0   <= i_tags;
        pend <= ~i_tags[2];
      end else if (take_odd) begin
        pend <= 1'b0;
      end

      // An odd pixel and a pending second word never coincide.
      if (take_odd) begin
        vld_q  <= 1'b1;
        data_q <= {y0, cb_out};
        tags_q <= t0;
      end else if (sec_v) begin
        vld_q  <= 1'b1;
        data_q <= sec_data;
        tags_q <= sec_tags;
      end else begin
        vld_q  <= 1'b0;
      end

      sec_v <= take_odd | lone;
      if (take_odd) begin
        sec_data <= {i_Y, cr_out};
        sec_tags <= i_tags;
      end else if (lone) begin
        sec_data <= {i_Y, i_Cb};
        sec_tags <= i_tags;
      end

      if (orphan)
        err_q <= 1'b1;
      else if (i_clr_err)
        err_q <= 1'b0;
    end
  end

  // Reset suppresses a word already in flight.
  assign o_valid = vld_q & ~i_rst;
  assign o_data  = data_q;
  assign o_tags  = tags_q;
  assign o_err   = err_q;

endmodule
